// File: rtl/or_event_collector_if.sv
// Signal bundle between the OR2 request line and the event collector.
// The master side drives the request/acknowledge inputs; the slave side is the collector.
`timescale 1ns/1ps

interface or_event_collector_if #(
    parameter int unsigned CNT_W = 8
) ();

    logic             y_in;
    logic             ack;
    logic             clr_cnt;
    logic             irq;
    logic             busy;
    logic [CNT_W-1:0] evt_cnt;
    logic             ovf;

    modport master (
        output y_in,
        output ack,
        output clr_cnt,
        input  irq,
        input  busy,
        input  evt_cnt,
        input  ovf
    );

    modport slave (
        input  y_in,
        input  ack,
        input  clr_cnt,
        output irq,
        output busy,
        output evt_cnt,
        output ovf
    );

endinterface

// File: rtl/or_event_collector.sv
// Synchronizes and debounces the OR2 gate output, raises one pending irq per accepted
// event until acknowledged, and keeps a saturating event count with a sticky overflow.
`timescale 1ns/1ps

module or_event_collector #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned DEB   = 3
) (
    input logic                 clk,
    input logic                 rst,
    or_event_collector_if.slave evt_if
);

    typedef enum logic [1:0] {
        StIdle,
        StFilter,
        StPending,
        StWaitLow
    } state_e;

    localparam logic [3:0]       StabLast = 4'(DEB - 1);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    logic             s1_q, s2_q;
    logic             ys;
    state_e           state_q, state_d;
    logic [3:0]       stab_q, stab_d;
    logic             irq_q, irq_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             accept;

    // Only the second synchronizer stage is allowed to reach the FSM.
    assign ys = s2_q;

    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        irq_d   = irq_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ys) begin
                    if (DEB == 1) begin
                        state_d = StPending;
                        accept  = 1'b1;
                    end else begin
                        state_d = StFilter;
                        stab_d  = 4'd1;
                    end
                end
            end
            StFilter: begin
                if (!ys) begin
                    state_d = StIdle;
                    stab_d  = '0;
                end else if (stab_q == StabLast) begin
                    state_d = StPending;
                    stab_d  = '0;
                    accept  = 1'b1;
                end else begin
                    stab_d = stab_q + 4'd1;
                end
            end
            StPending: begin
                if (evt_if.ack) begin
                    state_d = StWaitLow;
                    irq_d   = 1'b0;
                end
            end
            StWaitLow: begin
                if (!ys) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                stab_d  = '0;
            end
        endcase
        if (accept) begin
            irq_d = 1'b1;
        end
        busy_d = (state_d != StIdle);
    end

    // Clear is applied before the increment so a coincident accept still counts once.
    always_comb begin
        cnt_d = evt_if.clr_cnt ? '0 : cnt_q;
        ovf_d = evt_if.clr_cnt ? 1'b0 : ovf_q;
        if (accept) begin
            if (cnt_d == CntMax) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= StIdle;
            stab_q  <= '0;
            irq_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            s1_q    <= evt_if.y_in;
            s2_q    <= s1_q;
            state_q <= state_d;
            stab_q  <= stab_d;
            irq_q   <= irq_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign evt_if.irq     = irq_q;
    assign evt_if.busy    = busy_q;
    assign evt_if.evt_cnt = cnt_q;
    assign evt_if.ovf     = ovf_q;

endmodule

// File: tb/tb_or_event_collector.sv
// Bench for or_event_collector: two instances (CNT_W=8/DEB=3 and CNT_W=2/DEB=1) share stimulus
// and are compared against an event-level reference model plus directed expectations.
`timescale 1ns/1ps

module tb_or_event_collector;

    localparam int unsigned CW_A  = 8;
    localparam int unsigned DEB_A = 3;
    localparam int unsigned CW_B  = 2;
    localparam int unsigned DEB_B = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    or_event_collector_if #(.CNT_W(CW_A)) bus_a ();
    or_event_collector_if #(.CNT_W(CW_B)) bus_b ();

    or_event_collector #(.CNT_W(CW_A), .DEB(DEB_A)) dut_a (
        .clk    (clk),
        .rst    (rst),
        .evt_if (bus_a)
    );

    or_event_collector #(.CNT_W(CW_B), .DEB(DEB_B)) dut_b (
        .clk    (clk),
        .rst    (rst),
        .evt_if (bus_b)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: an event is DEB consecutive synchronized-high samples seen while armed;
    // it then stays pending until acked, and re-arming needs a synchronized low.
    bit dly0, dly1;
    int m_run   [2];
    bit m_armed [2];
    bit m_pend  [2];
    int m_cnt   [2];
    bit m_ovf   [2];
    int m_deb   [2] = '{DEB_A, DEB_B};
    int m_max   [2] = '{(1 << CW_A) - 1, (1 << CW_B) - 1};

    function automatic void model_step(bit y, bit a, bit c, bit r);
        bit ys;
        bit acc;
        if (r) begin
            dly0 = 1'b0;
            dly1 = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_run[i] = 0; m_armed[i] = 1'b1; m_pend[i] = 1'b0;
                m_cnt[i] = 0; m_ovf[i] = 1'b0;
            end
            return;
        end
        ys   = dly1;
        dly1 = dly0;
        dly0 = y;
        for (int i = 0; i < 2; i++) begin
            acc = 1'b0;
            if (m_armed[i]) begin
                if (ys) begin
                    m_run[i]++;
                    if (m_run[i] == m_deb[i]) begin
                        acc = 1'b1; m_armed[i] = 1'b0; m_pend[i] = 1'b1; m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end else if (m_pend[i]) begin
                if (a) m_pend[i] = 1'b0;
            end else if (!ys) begin
                m_armed[i] = 1'b1;
            end
            if (c) begin
                m_cnt[i] = 0; m_ovf[i] = 1'b0;
            end
            if (acc) begin
                if (m_cnt[i] == m_max[i]) m_ovf[i] = 1'b1;
                else m_cnt[i]++;
            end
        end
    endfunction

    // Packed view {irq, busy, ovf, cnt[7:0]} of the model for instance i.
    function automatic logic [10:0] exp_vec(int i);
        bit busy;
        busy = !(m_armed[i] && m_run[i] == 0);
        return {m_pend[i], busy, m_ovf[i], 8'(m_cnt[i])};
    endfunction

    function automatic logic [10:0] obs_a();
        return {bus_a.irq, bus_a.busy, bus_a.ovf, bus_a.evt_cnt};
    endfunction

    function automatic logic [10:0] obs_b();
        return {bus_b.irq, bus_b.busy, bus_b.ovf, 6'd0, bus_b.evt_cnt};
    endfunction

    // Apply inputs for one clock, advance the model at the edge, return at the next negedge.
    task automatic cycle(input bit y, input bit a, input bit c, input bit r);
        bus_a.y_in = y; bus_b.y_in = y;
        bus_a.ack = a; bus_b.ack = a;
        bus_a.clr_cnt = c; bus_b.clr_cnt = c;
        rst = r;
        @(posedge clk);
        model_step(y, a, c, r);
        @(negedge clk);
    endtask

    // Stimulus only: high for hi cycles, ack while still high, then low long enough to re-arm.
    task automatic event_pulse(input int hi);
        for (int k = 0; k < hi; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        n_total++;
        if (obs_a() !== 11'd0) $display("FAIL reset_a: got %b expected %b", obs_a(), 11'd0);
        else n_pass++;
        n_total++;
        if (obs_b() !== 11'd0) $display("FAIL reset_b: got %b expected %b", obs_b(), 11'd0);
        else n_pass++;
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (obs_a() !== exp_vec(0)) $display("FAIL reset_idle_a: got %b expected %b", obs_a(), exp_vec(0));
        else n_pass++;
    endtask

    task automatic test_glitch();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            n_total++;
            if (bus_a.irq !== 1'b0) $display("FAIL glitch_irq: got %b expected 0", bus_a.irq);
            else n_pass++;
        end
        n_total++;
        if (bus_a.evt_cnt !== 8'd0) $display("FAIL glitch_cnt: got %0d expected 0", bus_a.evt_cnt);
        else n_pass++;
        n_total++;
        if (bus_a.busy !== 1'b0) $display("FAIL glitch_busy: got %b expected 0", bus_a.busy);
        else n_pass++;
        n_total++;
        if (obs_b() !== exp_vec(1)) $display("FAIL glitch_b: got %b expected %b", obs_b(), exp_vec(1));
        else n_pass++;
    endtask

    task automatic test_clean_event();
        for (int k = 1; k <= 10; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            if (k == 4) begin
                n_total++;
                if (bus_a.irq !== 1'b0) $display("FAIL clean_irq_edge4: got %b expected 0", bus_a.irq);
                else n_pass++;
            end
            if (k == 5) begin
                n_total++;
                if ({bus_a.irq, bus_a.evt_cnt} !== {1'b1, 8'd1})
                    $display("FAIL clean_accept_edge5: got irq=%b cnt=%0d expected irq=1 cnt=1",
                             bus_a.irq, bus_a.evt_cnt);
                else n_pass++;
            end
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        n_total++;
        if ({bus_a.irq, bus_a.busy} !== 2'b01)
            $display("FAIL clean_ack: got irq/busy=%b expected 01", {bus_a.irq, bus_a.busy});
        else n_pass++;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            n_total++;
            if (bus_a.busy !== (k < 2)) $display("FAIL clean_busy_low_m%0d: got %b expected %b",
                                                 k, bus_a.busy, (k < 2));
            else n_pass++;
        end
        n_total++;
        if (obs_a() !== exp_vec(0)) $display("FAIL clean_model_a: got %b expected %b", obs_a(), exp_vec(0));
        else n_pass++;
    endtask

    task automatic test_saturation();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int e = 1; e <= 5; e++) begin
            event_pulse(3);
            if (e == 3) begin
                n_total++;
                if ({bus_b.ovf, bus_b.evt_cnt} !== 3'b011)
                    $display("FAIL sat_three: got ovf=%b cnt=%0d expected ovf=0 cnt=3",
                             bus_b.ovf, bus_b.evt_cnt);
                else n_pass++;
            end
        end
        n_total++;
        if ({bus_b.ovf, bus_b.evt_cnt} !== 3'b111)
            $display("FAIL sat_five: got ovf=%b cnt=%0d expected ovf=1 cnt=3", bus_b.ovf, bus_b.evt_cnt);
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        n_total++;
        if ({bus_b.ovf, bus_b.evt_cnt} !== 3'b000)
            $display("FAIL sat_clear: got ovf=%b cnt=%0d expected ovf=0 cnt=0", bus_b.ovf, bus_b.evt_cnt);
        else n_pass++;
        n_total++;
        if (obs_a() !== exp_vec(0)) $display("FAIL sat_model_a: got %b expected %b", obs_a(), exp_vec(0));
        else n_pass++;
    endtask

    task automatic test_coincident_clear();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        event_pulse(6);
        event_pulse(6);
        n_total++;
        if (bus_a.evt_cnt !== 8'd2) $display("FAIL coinc_pre: got %0d expected 2", bus_a.evt_cnt);
        else n_pass++;
        for (int k = 1; k <= 4; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        n_total++;
        if ({bus_a.irq, bus_a.ovf, bus_a.evt_cnt} !== {1'b1, 1'b0, 8'd1})
            $display("FAIL coinc_accept: got irq=%b ovf=%b cnt=%0d expected irq=1 ovf=0 cnt=1",
                     bus_a.irq, bus_a.ovf, bus_a.evt_cnt);
        else n_pass++;
        n_total++;
        if (obs_b() !== exp_vec(1)) $display("FAIL coinc_model_b: got %b expected %b", obs_b(), exp_vec(1));
        else n_pass++;
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int e = 0; e < 3; e++) event_pulse(6);
        for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        n_total++;
        if ({bus_a.irq, bus_a.evt_cnt} !== {1'b1, 8'd4})
            $display("FAIL rstmid_pending: got irq=%b cnt=%0d expected irq=1 cnt=4",
                     bus_a.irq, bus_a.evt_cnt);
        else n_pass++;
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        n_total++;
        if (obs_a() !== 11'd0) $display("FAIL rstmid_clear: got %b expected %b", obs_a(), 11'd0);
        else n_pass++;
        for (int k = 1; k <= 5; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            if (k == 4) begin
                n_total++;
                if (bus_a.irq !== 1'b0) $display("FAIL rstmid_edge4: got %b expected 0", bus_a.irq);
                else n_pass++;
            end
        end
        n_total++;
        if ({bus_a.irq, bus_a.evt_cnt} !== {1'b1, 8'd1})
            $display("FAIL rstmid_rearm: got irq=%b cnt=%0d expected irq=1 cnt=1",
                     bus_a.irq, bus_a.evt_cnt);
        else n_pass++;
    endtask

    task automatic test_spurious_and_merge();
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        n_total++;
        if (obs_a() !== {1'b0, 1'b0, 1'b0, 8'd1})
            $display("FAIL ack_idle: got %b expected %b", obs_a(), {3'b000, 8'd1});
        else n_pass++;
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        n_total++;
        if ({bus_a.irq, bus_a.busy} !== 2'b01)
            $display("FAIL ack_filter: got irq/busy=%b expected 01", {bus_a.irq, bus_a.busy});
        else n_pass++;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        n_total++;
        if ({bus_a.irq, bus_a.evt_cnt} !== {1'b1, 8'd2})
            $display("FAIL filter_accept: got irq=%b cnt=%0d expected irq=1 cnt=2",
                     bus_a.irq, bus_a.evt_cnt);
        else n_pass++;
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        n_total++;
        if ({bus_a.irq, bus_a.evt_cnt} !== {1'b1, 8'd2})
            $display("FAIL merge: got irq=%b cnt=%0d expected irq=1 cnt=2", bus_a.irq, bus_a.evt_cnt);
        else n_pass++;
        n_total++;
        if (obs_b() !== exp_vec(1)) $display("FAIL merge_model_b: got %b expected %b", obs_b(), exp_vec(1));
        else n_pass++;
    endtask

    task automatic test_random();
        bit y, a, c, r;
        y = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 18) y = ~y;
            a = ($urandom_range(0, 7) == 0);
            c = ($urandom_range(0, 39) == 0);
            r = ($urandom_range(0, 299) == 0);
            cycle(y, a, c, r);
            n_total++;
            if (obs_a() !== exp_vec(0))
                $display("FAIL rand_a cyc %0d: got %b expected %b", n, obs_a(), exp_vec(0));
            else n_pass++;
            n_total++;
            if (obs_b() !== exp_vec(1))
                $display("FAIL rand_b cyc %0d: got %b expected %b", n, obs_b(), exp_vec(1));
            else n_pass++;
        end
    endtask

    initial begin
        bus_a.y_in = 1'b0; bus_a.ack = 1'b0; bus_a.clr_cnt = 1'b0;
        bus_b.y_in = 1'b0; bus_b.ack = 1'b0; bus_b.clr_cnt = 1'b0;
        test_reset();
        test_glitch();
        test_clean_event();
        test_saturation();
        test_coincident_clear();
        test_reset_mid();
        test_spurious_and_merge();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/or_event_collector.md
# or_event_collector

Sequential stage directly downstream of the switch-level OR2 gate: takes the gate output `y` (two wired request lines merged into one level), synchronizes it into the `clk` domain, rejects glitches shorter than `DEB` cycles, and turns each accepted high level into a single pending interrupt held until acknowledged. It also keeps a saturating count of accepted events with a sticky overflow flag, so software can read how many requests the OR stage has produced.

## Interface
- `CNT_W`, 8: width of event counter `evt_cnt`; legal 1..16.
- `DEB`, 3: consecutive synchronized-high samples required to accept an event; legal 1..15.

- `clk`  input  1  single clock, rising-edge.
- `rst`  input  1  synchronous, active-high reset.
- `y_in`  input  1  OR2 gate output; asynchronous to `clk`, may glitch.
- `ack`  input  1  one-cycle acknowledge of pending `irq`.
- `clr_cnt`  input  1  clear `evt_cnt` and `ovf`.
- `irq`  output  1  registered; high while an accepted event awaits `ack`.
- `busy`  output  1  registered; high whenever FSM is not IDLE.
- `evt_cnt`  output  CNT_W  registered count of accepted events, saturating.
- `ovf`  output  1  registered, sticky; increment attempted at all-ones.

## Operation
- Reset (`rst`=1 at a rising edge): sync flops `s1`,`s2`=0, state IDLE, debounce counter 0, `irq`=0, `busy`=0, `evt_cnt`=0, `ovf`=0. Reset overrides all other inputs.
- Synchronizer: `s1`<=`y_in`, `s2`<=`s1`; FSM uses `ys`=`s2` only.
- States: IDLE, FILTER, PENDING, WAIT_LOW.
- IDLE: `ys`=1 -> FILTER with `stab`=1; if `DEB`=1 go straight to PENDING (accept). `ys`=0 -> stay.
- FILTER: `ys`=0 -> IDLE (glitch dropped, nothing counted). `ys`=1 and `stab`=`DEB`-1 -> PENDING (accept); else `stab`++.
- Accept (any transition into PENDING): `irq`<=1; `evt_cnt`++ unless all-ones, in which case `evt_cnt` holds and `ovf`<=1.
- PENDING: `irq` held high regardless of `ys`; further activity on `y_in` is merged (not counted). `ack`=1 -> WAIT_LOW, `irq`<=0.
- WAIT_LOW: `ys`=0 -> IDLE; else stay. A new event needs a fresh low-to-high sequence.
- `ack` in IDLE, FILTER, WAIT_LOW: ignored, no side effect.
- `clr_cnt`=1: `evt_cnt`<=0, `ovf`<=0; if coincident with accept, result `evt_cnt`=1, `ovf`=0 (clear first, then increment). Does not affect FSM or `irq`.
- `busy`<=1 when next state is not IDLE.
- `y_in` held high through reset is treated as a new event after release.

## Timing
- Edge numbering: edge 1 = first edge sampling `y_in`=1 into `s1`.
- `ys`=1 visible after edge 2; IDLE consumes it at edge 3.
- `irq` and `evt_cnt` update at edge `DEB`+2 if `ys` stays high; minimum stable high at `y_in` = `DEB` cycles.
- `ack` sampled at edge N in PENDING -> `irq`=0 after edge N.
- After `y_in` falls (sampled low at edge M) in WAIT_LOW: `busy`=0 after edge M+2.
- All outputs registered; no combinational path from any input to any output.

## Test plan
- Glitch reject, DEB=3: `y_in` high for 2 cycles then low -> `irq` never asserts, `evt_cnt`=0, `busy` returns to 0.
- Clean event, DEB=3: `y_in` high 10 cycles -> `irq`=1 and `evt_cnt`=1 after edge 5; `ack` pulse -> `irq`=0 next edge; `busy` stays 1 until 2 edges after `y_in` sampled low.
- Saturation, CNT_W=2: 5 clean events each acked -> `evt_cnt`=3, `ovf`=1; `clr_cnt` pulse -> `evt_cnt`=0, `ovf`=0.
- Coincident clear: `clr_cnt` asserted on the accept edge with `evt_cnt`=2 -> `evt_cnt`=1, `ovf`=0, `irq`=1.
- Reset mid-operation: `rst` in PENDING with `y_in` high, `evt_cnt`=4 -> all outputs 0 after edge; after release `irq` re-asserts DEB+2 edges later, `evt_cnt`=1.
- Spurious ack / merge: `ack` in IDLE and FILTER changes nothing; second `y_in` pulse during PENDING -> `evt_cnt` unchanged, single `irq`.
